// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// FSM encoding, packet cap default and UART frame timing.
package uart_tx_arbiter_pkg;

  localparam int unsigned MAX_PKT_BYTES_DEF   = 16;

  // UART at 9600 baud from a 100 MHz clock.
  localparam int unsigned UART_BIT_PERIOD     = 10416;
  localparam int unsigned UART_BITS_PER_FRAME = 10;
  localparam int unsigned UART_FRAME_CYCLES   = UART_BIT_PERIOD * UART_BITS_PER_FRAME;
  localparam int unsigned MIN_ACCEPT_GAP      = UART_FRAME_CYCLES + 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GRANTED   = 3'd1,
    ST_SEND      = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_REQ0 = 2'b01;
  localparam logic [1:0] GRANT_REQ1 = 2'b10;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick2.sv
// Two-way round-robin winner selection: on a tie the requester that was
// not served most recently wins; a lone valid requester always wins.
module rr_pick2
  import uart_tx_arbiter_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_served_i,
  output logic [1:0] winner_o
);

  always_comb begin
    winner_o = GRANT_NONE;
    unique case (valid_i)
      2'b01:   winner_o = GRANT_REQ0;
      2'b10:   winner_o = GRANT_REQ1;
      2'b11:   winner_o = last_served_i ? GRANT_REQ0 : GRANT_REQ1;
      default: winner_o = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter feeding one byte at a time to a UART
// transmit controller that sits beside this block at the top level.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int unsigned MAX_PKT_BYTES = MAX_PKT_BYTES_DEF
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       req0_valid_i,
  input  logic [7:0] req0_data_i,
  input  logic       req0_last_i,
  output logic       req0_accept_o,
  input  logic       req1_valid_i,
  input  logic [7:0] req1_data_i,
  input  logic       req1_last_i,
  output logic       req1_accept_o,
  output logic       tx_send_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_ready_i,
  output logic [1:0] grant_o,
  output state_e     dbg_state_o
);

  localparam int unsigned CNT_W = $clog2(MAX_PKT_BYTES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PKT_BYTES);

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             last_flag_q, last_flag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_served_q, last_served_d;

  logic [1:0]       winner;
  logic             owner_valid;
  logic [7:0]       owner_data;
  logic             owner_last;
  logic             capture;
  logic             pkt_end;

  rr_pick2 u_pick (
    .valid_i       ({req1_valid_i, req0_valid_i}),
    .last_served_i (last_served_q),
    .winner_o      (winner)
  );

  // Handshake: a requester holds VALID/DATA/LAST stable until it sees its
  // ACCEPT high; the byte is taken on the rising edge that ends that cycle.
  // ACCEPT only rises in GRANTED, for the owner, while the UART reports idle.
  always_comb begin
    owner_valid = (grant_q[0] & req0_valid_i) | (grant_q[1] & req1_valid_i);
    owner_data  = grant_q[1] ? req1_data_i : req0_data_i;
    owner_last  = grant_q[1] ? req1_last_i : req0_last_i;
    capture     = rstn_i && (state_q == ST_GRANTED) && owner_valid && tx_ready_i;
    pkt_end     = last_flag_q || (cnt_q == CNT_MAX);
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    tx_data_d     = tx_data_q;
    last_flag_d   = last_flag_q;
    cnt_d         = cnt_q;
    last_served_d = last_served_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          grant_d = winner;
          state_d = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (capture) begin
          tx_data_d   = owner_data;
          last_flag_d = owner_last;
          cnt_d       = cnt_q + 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_ready_i) state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_ready_i) begin
          if (pkt_end) begin
            state_d       = ST_IDLE;
            grant_d       = GRANT_NONE;
            cnt_d         = '0;
            last_flag_d   = 1'b0;
            last_served_d = grant_q[1];
          end else begin
            state_d = ST_GRANTED;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Last-served starts at requester 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q       <= ST_IDLE;
      grant_q       <= GRANT_NONE;
      tx_data_q     <= 8'h00;
      last_flag_q   <= 1'b0;
      cnt_q         <= '0;
      last_served_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      tx_data_q     <= tx_data_d;
      last_flag_q   <= last_flag_d;
      cnt_q         <= cnt_d;
      last_served_q <= last_served_d;
    end
  end

  always_comb begin
    req0_accept_o = capture & grant_q[0];
    req1_accept_o = capture & grant_q[1];
    tx_send_o     = (state_q == ST_SEND);
    tx_data_o     = tx_data_q;
    grant_o       = grant_q;
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a short-frame UART model and an
// in-order byte scoreboard.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int MAXB  = 4;
  localparam int FRAME = 12;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic [7:0] req0_data, req1_data;
  logic       req0_accept, req1_accept, tx_send;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b1;
  logic [1:0] grant;
  state_e     dbg_state;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  logic pend = 1'b0;
  int   dly = 0;
  int   frame_cnt = 0;
  logic cross_acc = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.MAX_PKT_BYTES(MAXB)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_last_i(req0_last),
    .req0_accept_o(req0_accept),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_last_i(req1_last),
    .req1_accept_o(req1_accept),
    .tx_send_o(tx_send), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
    .grant_o(grant), .dbg_state_o(dbg_state)
  );

  // UART model: goes busy a few cycles after a start pulse, stays busy one
  // short frame, and checks every started byte against the expected queue.
  always @(posedge clk) begin
    if (tx_send) begin
      tests++;
      assert (tx_ready === 1'b1 && pend === 1'b0) else begin
        fails++;
        $error("FAIL tx_overlap: ready=%0b pend=%0b, required ready=1 pend=0", tx_ready, pend);
      end
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL uart_extra: got byte %h, required no byte", tx_data);
      end
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        tests++;
        assert (tx_data === e) else begin
          fails++;
          $error("FAIL uart_byte: got %h, required %h", tx_data, e);
        end
      end
      pend <= 1'b1;
      dly  <= 2;
    end else if (pend) begin
      if (dly != 0) dly <= dly - 1;
      else begin
        pend      <= 1'b0;
        tx_ready  <= 1'b0;
        frame_cnt <= FRAME;
      end
    end else if (!tx_ready) begin
      if (frame_cnt == 1) tx_ready <= 1'b1;
      frame_cnt <= frame_cnt - 1;
    end
  end

  always @(negedge clk) begin
    if ((req0_accept && !grant[0]) || (req1_accept && !grant[1])) cross_acc <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input bit port, input logic [7:0] d, input logic l, input bit drop);
    bit got;
    got = 1'b0;
    if (port == 1'b0) begin req0_valid = 1'b1; req0_data = d; req0_last = l; end
    else              begin req1_valid = 1'b1; req1_data = d; req1_last = l; end
    for (int k = 0; k < 400; k++) begin
      #1;
      if ((port == 1'b0 && req0_accept) || (port == 1'b1 && req1_accept)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check(port ? "accept1_seen" : "accept0_seen", 32'(got), 32'd1);
    if (got) exp_q.push_back(d);
    @(negedge clk);
    if (drop) begin
      if (port == 1'b0) req0_valid = 1'b0;
      else              req1_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (grant == GRANT_NONE) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("idle_reached", 32'(ok), 32'd1);
    check("ready_at_release", 32'(tx_ready), 32'd1);
  endtask

  task automatic wait_owner(output logic [1:0] g);
    g = GRANT_NONE;
    for (int k = 0; k < 400; k++) begin
      if (grant != GRANT_NONE) begin g = grant; break; end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    bit flag;
    bit ok;

    // Reset values
    rstn = 1'b0;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_tx_send", 32'(tx_send), 32'h0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_accept0", 32'(req0_accept), 32'h0);
    check("rst_accept1", 32'(req1_accept), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    @(negedge clk);

    // Single byte A5 from requester 0
    req0_valid = 1'b1; req0_data = 8'hA5; req0_last = 1'b1;
    #1;
    check("single_grant_idle", 32'(grant), 32'h0);
    check("single_no_accept_idle", 32'(req0_accept), 32'h0);
    @(negedge clk);
    check("single_grant", 32'(grant), 32'(GRANT_REQ0));
    check("single_state_granted", 32'(dbg_state), 32'(ST_GRANTED));
    check("single_accept0", 32'(req0_accept), 32'h1);
    exp_q.push_back(8'hA5);
    @(negedge clk);
    check("single_tx_send", 32'(tx_send), 32'h1);
    check("single_tx_data", 32'(tx_data), 32'hA5);
    check("single_accept0_off", 32'(req0_accept), 32'h0);
    req0_valid = 1'b0;
    @(negedge clk);
    check("single_tx_send_off", 32'(tx_send), 32'h0);
    check("single_state_wait_busy", 32'(dbg_state), 32'(ST_WAIT_BUSY));
    wait_idle();
    check("single_tx_data_held", 32'(tx_data), 32'hA5);

    // Tie-break alternates between requesters
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hB0; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hC1; req1_last = 1'b1;
    wait_owner(g);
    check("tie1_owner", 32'(g), 32'(GRANT_REQ0));
    send_byte(1'b0, 8'hB0, 1'b1, 1'b0);
    req0_data = 8'hB1;
    wait_idle();
    wait_owner(g);
    check("tie2_owner", 32'(g), 32'(GRANT_REQ1));
    send_byte(1'b1, 8'hC1, 1'b1, 1'b1);
    wait_idle();
    wait_owner(g);
    check("tie3_owner", 32'(g), 32'(GRANT_REQ0));
    send_byte(1'b0, 8'hB1, 1'b1, 1'b1);
    wait_idle();

    // Packet lock: requester 1 waits for the whole 3-byte packet
    req0_valid = 1'b1; req0_data = 8'h11; req0_last = 1'b0;
    wait_owner(g);
    check("lock_owner", 32'(g), 32'(GRANT_REQ0));
    req1_valid = 1'b1; req1_data = 8'h99; req1_last = 1'b1;
    send_byte(1'b0, 8'h11, 1'b0, 1'b0);
    send_byte(1'b0, 8'h22, 1'b0, 1'b0);
    send_byte(1'b0, 8'h33, 1'b1, 1'b1);
    wait_idle();
    wait_owner(g);
    check("lock_next_owner", 32'(g), 32'(GRANT_REQ1));
    send_byte(1'b1, 8'h99, 1'b1, 1'b1);
    wait_idle();
    check("lock_no_cross_accept", 32'(cross_acc), 32'h0);

    // Packet cap at MAXB bytes hands the grant to the waiting requester
    req0_valid = 1'b1; req0_data = 8'h40; req0_last = 1'b0;
    wait_owner(g);
    check("cap_owner", 32'(g), 32'(GRANT_REQ0));
    req1_valid = 1'b1; req1_data = 8'h9A; req1_last = 1'b1;
    send_byte(1'b0, 8'h40, 1'b0, 1'b0);
    send_byte(1'b0, 8'h41, 1'b0, 1'b0);
    send_byte(1'b0, 8'h42, 1'b0, 1'b0);
    send_byte(1'b0, 8'h43, 1'b0, 1'b0);
    req0_data = 8'h44;
    wait_idle();
    wait_owner(g);
    check("cap_next_owner", 32'(g), 32'(GRANT_REQ1));
    send_byte(1'b1, 8'h9A, 1'b1, 1'b1);
    wait_idle();
    wait_owner(g);
    check("cap_resume_owner", 32'(g), 32'(GRANT_REQ0));
    send_byte(1'b0, 8'h44, 1'b0, 1'b0);
    send_byte(1'b0, 8'h45, 1'b1, 1'b1);
    wait_idle();

    // Stall: owner drops VALID for 50 cycles mid-packet
    send_byte(1'b0, 8'h50, 1'b0, 1'b1);
    flag = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (grant !== GRANT_REQ0 || tx_send !== 1'b0) flag = 1'b1;
    end
    check("stall_grant_held_no_send", 32'(flag), 32'h0);
    check("stall_state", 32'(dbg_state), 32'(ST_GRANTED));
    send_byte(1'b0, 8'h51, 1'b1, 1'b1);
    wait_idle();

    // Reset during WAIT_DONE of byte 2 of 3
    send_byte(1'b0, 8'h61, 1'b0, 1'b0);
    send_byte(1'b0, 8'h62, 1'b0, 1'b0);
    req0_data = 8'h63; req0_last = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (dbg_state == ST_WAIT_DONE) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("mid_reached_wait_done", 32'(ok), 32'h1);
    rstn = 1'b0;
    req0_data = 8'h70;
    @(negedge clk);
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_tx_send", 32'(tx_send), 32'h0);
    check("mid_rst_tx_data", 32'(tx_data), 32'h00);
    check("mid_rst_accept0", 32'(req0_accept), 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rstn = 1'b1;
    flag = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (tx_ready) begin ok = 1'b1; break; end
      if (req0_accept || tx_send) flag = 1'b1;
      @(negedge clk);
    end
    check("mid_ready_returned", 32'(ok), 32'h1);
    check("mid_no_capture_while_busy", 32'(flag), 32'h0);
    send_byte(1'b0, 8'h70, 1'b1, 1'b1);
    wait_idle();

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    check("no_cross_accept", 32'(cross_acc), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
